// File: rtl/pirdsp_acc_pkg.sv
// -----------------------------------------------------------------------------
// pirdsp_acc_pkg
// Shared definitions for the SIMD accumulator behind the fracturable
// 27x18 multiplier.
//   - mode encodings of the multiplier result buses
//   - lane count / lane width per mode
//   - carry-kill mask helper: a 1 at bit i means no carry may enter bit i
//     (bit i is the LSB of a lane)
// -----------------------------------------------------------------------------
package pirdsp_acc_pkg;

    localparam int ACC_W    = 48;
    localparam int MAX_LANE = 8;

    localparam logic [1:0] MODE_27x18   = 2'b00;
    localparam logic [1:0] MODE_SUM_9x9 = 2'b01;
    localparam logic [1:0] MODE_SUM_4x4 = 2'b10;
    localparam logic [1:0] MODE_SUM_2x2 = 2'b11;

    localparam int LANES_27x18   = 1;
    localparam int LANES_SUM_9x9 = 2;
    localparam int LANES_SUM_4x4 = 4;
    localparam int LANES_SUM_2x2 = 8;

    localparam int W_27x18   = 48;
    localparam int W_SUM_9x9 = 24;
    localparam int W_SUM_4x4 = 12;
    localparam int W_SUM_2x2 = 6;

    function automatic int lane_width(input logic [1:0] mode);
        case (mode)
            MODE_27x18:   return W_27x18;
            MODE_SUM_9x9: return W_SUM_9x9;
            MODE_SUM_4x4: return W_SUM_4x4;
            default:      return W_SUM_2x2;
        endcase
    endfunction

    function automatic int lane_count(input logic [1:0] mode);
        case (mode)
            MODE_27x18:   return LANES_27x18;
            MODE_SUM_9x9: return LANES_SUM_9x9;
            MODE_SUM_4x4: return LANES_SUM_4x4;
            default:      return LANES_SUM_2x2;
        endcase
    endfunction

    // Marks the LSB of every lane; a carry entering one of these bits is dropped.
    function automatic logic [ACC_W-1:0] carry_kill_mask(input logic [1:0] mode);
        logic [ACC_W-1:0] mask;
        int               w;
        mask = '0;
        w    = lane_width(mode);
        for (int i = 0; i < ACC_W; i++) begin
            mask[i] = ((i % w) == 0);
        end
        return mask;
    endfunction

endpackage

// File: rtl/pirdsp_seg_adder.sv
// -----------------------------------------------------------------------------
// pirdsp_seg_adder
// 48-bit adder split into lanes according to mode; no carry crosses a lane
// boundary. Reports per-lane overflow (signed: two's-complement overflow,
// unsigned: carry out of the lane MSB).
// With ACC_SATURATE_EN defined and parameter SATURATE set, an overflowing
// lane clamps to its signed max/min or unsigned max instead of wrapping.
// Ports:
//   a, b  : 48-bit operands, lane k in bits [k*W+W-1 : k*W]
//   mode  : lane configuration (see pirdsp_acc_pkg)
//   sign  : lanes are two's-complement when 1
//   sum   : lane-segmented sum
//   ovf   : per-lane overflow, bits at and above the lane count are 0
// -----------------------------------------------------------------------------
module pirdsp_seg_adder
    import pirdsp_acc_pkg::*;
`ifdef ACC_SATURATE_EN
#(
    parameter bit SATURATE = 1'b0
)
`endif
(
    input  logic [ACC_W-1:0]    a,
    input  logic [ACC_W-1:0]    b,
    input  logic [1:0]          mode,
    input  logic                sign,
    output logic [ACC_W-1:0]    sum,
    output logic [MAX_LANE-1:0] ovf
);

    logic [ACC_W-1:0] kill;
    logic [ACC_W-1:0] raw;
    logic [ACC_W-1:0] cout;
    logic             c;
    logic             cin;
    logic [5:0]       msb;
    int               w;
    int               n;
`ifdef ACC_SATURATE_EN
    logic [2:0]       lane_idx;
    logic [5:0]       sat_msb;
`endif

    // Bit-serial ripple with the carry forced to zero at each lane LSB, then
    // overflow taken at each lane MSB; saturation overrides whole lanes.
    always_comb begin
        kill = carry_kill_mask(mode);
        w    = lane_width(mode);
        n    = lane_count(mode);
        c    = 1'b0;
        cin  = 1'b0;
        raw  = '0;
        cout = '0;
        ovf  = '0;
        msb  = '0;
        for (int i = 0; i < ACC_W; i++) begin
            cin     = kill[i] ? 1'b0 : c;
            raw[i]  = a[i] ^ b[i] ^ cin;
            c       = (a[i] & b[i]) | (a[i] & cin) | (b[i] & cin);
            cout[i] = c;
        end
        for (int k = 0; k < MAX_LANE; k++) begin
            if (k < n) begin
                msb = 6'(k * w + w - 1);
                if (sign) begin
                    ovf[k] = (a[msb] == b[msb]) && (raw[msb] != a[msb]);
                end else begin
                    ovf[k] = cout[msb];
                end
            end
        end
        sum = raw;
`ifdef ACC_SATURATE_EN
        lane_idx = '0;
        sat_msb  = '0;
        if (SATURATE) begin
            for (int i = 0; i < ACC_W; i++) begin
                lane_idx = 3'(i / w);
                sat_msb  = 6'((i / w) * w + w - 1);
                if (ovf[lane_idx]) begin
                    if (sign) begin
                        // Signed overflow means both operands share the sign
                        // bit, which picks max (0111..) or min (1000..).
                        sum[i] = ((i % w) == (w - 1)) ? a[sat_msb] : ~a[sat_msb];
                    end else begin
                        sum[i] = 1'b1;
                    end
                end
            end
        end
`endif
    end

endmodule

// File: rtl/pirdsp_simd_accumulator.sv
// -----------------------------------------------------------------------------
// pirdsp_simd_accumulator
// Two-stage accumulator downstream of the fracturable multiplier.
//   Stage 1: lane-segmented pre-add of result_0 + result_1 into a 48-bit addend.
//   Stage 2: accumulates ACC_LEN beats per lane, then presents acc_out with a
//            one-cycle out_valid pulse and the OR of per-lane overflow flags.
// Optional build macro: ACC_SATURATE_EN (lanes clamp on overflow instead of
// wrapping; the pre-add always wraps).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   in_valid          : qualifies result_0/result_1/sign/mode
//   result_0/result_1 : 45-bit partial result buses
//   sign              : lanes signed
//   mode              : 00=1x48, 01=2x24, 10=4x12, 11=8x6
//   acc_clear         : abort current accumulation, no output
//   acc_out           : last completed accumulation
//   out_valid         : pulse when acc_out updates
//   lane_ovf          : per-lane overflow of the completed accumulation
//   mode_err          : sticky, mode changed mid-accumulation
// -----------------------------------------------------------------------------
module pirdsp_simd_accumulator
    import pirdsp_acc_pkg::*;
#(
    parameter int ACC_LEN = 4
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [44:0]         result_0,
    input  logic [44:0]         result_1,
    input  logic                sign,
    input  logic [1:0]          mode,
    input  logic                acc_clear,
    output logic [ACC_W-1:0]    acc_out,
    output logic                out_valid,
    output logic [MAX_LANE-1:0] lane_ovf,
    output logic                mode_err
);

    localparam logic [7:0] ACC_LEN_8 = 8'(ACC_LEN);

    logic [ACC_W-1:0]    pre_sum;
    logic [MAX_LANE-1:0] pre_ovf_unused;
    logic [ACC_W-1:0]    addend;

    logic                s1_valid;
    logic [ACC_W-1:0]    s1_addend;
    logic [1:0]          s1_mode;
    logic                s1_sign;

    logic [ACC_W-1:0]    acc_lanes;
    logic [MAX_LANE-1:0] acc_flags;
    logic [7:0]          beat_cnt;
    logic [1:0]          lat_mode;

    logic [ACC_W-1:0]    acc_sum;
    logic [MAX_LANE-1:0] acc_ovf;
    logic                start;
    logic                mode_change;
    logic [ACC_W-1:0]    next_lanes;
    logic [MAX_LANE-1:0] next_flags;
    logic [7:0]          next_cnt;
    logic                done;

    pirdsp_seg_adder u_pre_add (
        .a    ({3'b000, result_0}),
        .b    ({3'b000, result_1}),
        .mode (mode),
        .sign (sign),
        .sum  (pre_sum),
        .ovf  (pre_ovf_unused)
    );

    // In 1x48 mode the multiplier result is only 45 bits wide, so the wrapped
    // 45-bit sum is extended by the operand signedness to fill the lane.
    always_comb begin
        addend = pre_sum;
        if (mode == MODE_27x18) begin
            addend = {{3{sign & pre_sum[44]}}, pre_sum[44:0]};
        end
    end

    // Stage 1 register: addend plus the beat's qualifiers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_addend <= '0;
            s1_mode   <= MODE_27x18;
            s1_sign   <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_addend <= addend;
            s1_mode   <= mode;
            s1_sign   <= sign;
        end
    end

    pirdsp_seg_adder
`ifdef ACC_SATURATE_EN
    #(
        .SATURATE (1'b1)
    )
`endif
    u_acc_add (
        .a    (acc_lanes),
        .b    (s1_addend),
        .mode (s1_mode),
        .sign (s1_sign),
        .sum  (acc_sum),
        .ovf  (acc_ovf)
    );

    // A beat opens a new accumulation when the counter is idle, or when its
    // mode differs from the one latched at the start (which is an error).
    always_comb begin
        mode_change = (beat_cnt != 8'd0) && (s1_mode != lat_mode);
        start       = (beat_cnt == 8'd0) || mode_change;
        next_lanes  = start ? s1_addend : acc_sum;
        next_flags  = start ? '0 : (acc_flags | acc_ovf);
        next_cnt    = start ? 8'd1 : (beat_cnt + 8'd1);
        done        = (next_cnt == ACC_LEN_8);
    end

    // Stage 2: accumulator, beat counter and result registers. acc_clear
    // wins over a beat arriving from stage 1 in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_lanes <= '0;
            acc_flags <= '0;
            beat_cnt  <= '0;
            lat_mode  <= MODE_27x18;
            acc_out   <= '0;
            lane_ovf  <= '0;
            out_valid <= 1'b0;
            mode_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (acc_clear) begin
                acc_lanes <= '0;
                acc_flags <= '0;
                beat_cnt  <= '0;
            end else if (s1_valid) begin
                if (mode_change) begin
                    mode_err <= 1'b1;
                end
                if (start) begin
                    lat_mode <= s1_mode;
                end
                acc_lanes <= next_lanes;
                acc_flags <= next_flags;
                if (done) begin
                    beat_cnt  <= '0;
                    acc_out   <= next_lanes;
                    lane_ovf  <= next_flags;
                    out_valid <= 1'b1;
                end else begin
                    beat_cnt  <= next_cnt;
                end
            end
        end
    end

endmodule
